// File: rtl/multdiv_pkg.sv
// multdiv_pkg: op codes, FSM states and default width for the iterative multiply/divide unit.
package multdiv_pkg;
  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_t;
  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIX} md_state_t;
  localparam int MD_W = 32;
endpackage

// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: iterative shift-add multiply / restoring divide with HI/LO result registers.
// Optional `define DIV0_TRAP_EN: division by zero skips CALC and pulses div_zero with done.
module mult_div_sequencer
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  md_state_t state_q, state_d;
  md_op_t op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, done_q, done_d, dz_q, dz_d, trap_q, trap_d;
  logic trap, sgn, is_div, rem_ge;
  logic [WIDTH:0] mul_sum, rem_sh, rem_sub;
  logic [2*WIDTH-1:0] prod;
`ifdef DIV0_TRAP_EN
  assign trap = op[1] && b == '0;
`else
  assign trap = 1'b0;
`endif
  assign sgn = op == MD_MULT || op == MD_DIV;
  assign is_div = op_q == MD_DIV || op_q == MD_DIVU;
  // Mult and div share {acc_hi, acc_lo}; only the per-step datapath differs.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
  assign rem_sh = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign rem_ge = rem_sh >= {1'b0, b_q};
  assign rem_sub = rem_sh - {1'b0, b_q};
  assign prod = {acc_hi_q, acc_lo_q};
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    b_d = b_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    trap_d = trap_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    dz_d = 1'b0;
    case (state_q)
      MD_IDLE: if (start) begin
        op_d = md_op_t'(op);
        acc_hi_d = '0;
        acc_lo_d = sgn && a[WIDTH-1] ? -a : a;
        b_d = sgn && b[WIDTH-1] ? -b : b;
        neg_res_d = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_rem_d = sgn && a[WIDTH-1];
        cnt_d = CW'(WIDTH - 1);
        trap_d = trap;
        state_d = trap ? MD_FIX : MD_CALC;
      end
      MD_CALC: begin
        cnt_d = cnt_q - 1'b1;
        {acc_hi_d, acc_lo_d} = is_div
          ? {rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0], acc_lo_q[WIDTH-2:0], rem_ge}
          : {mul_sum, acc_lo_q[WIDTH-1:1]};
        state_d = cnt_q == '0 ? MD_FIX : MD_CALC;
      end
      MD_FIX: begin
        state_d = MD_IDLE;
        done_d = 1'b1;
        dz_d = trap_q;
        if (!trap_q)
          {hi_d, lo_d} = is_div
            ? {neg_rem_q ? -acc_hi_q : acc_hi_q, neg_res_q ? -acc_lo_q : acc_lo_q}
            : (neg_res_q ? -prod : prod);
      end
      default: state_d = MD_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= MD_IDLE;
      op_q <= MD_MULT;
      cnt_q <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      b_q <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      trap_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      b_q <= b_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      trap_q <= trap_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
      dz_q <= dz_d;
    end
  end
  assign busy = state_q != MD_IDLE;
  assign done = done_q;
  assign div_zero = dz_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule
